// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FP instruction sequencer.
package fpu_ctrl_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_t;

    // RISC-V rounding-mode encodings; 101/110 are reserved, DYN defers to frm
    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100,
        RM_DYN = 3'b111
    } rm_t;

    // Bit positions inside the 5-bit fflags vector {NV,DZ,OF,UF,NX}
    typedef enum logic [2:0] {
        FLAG_NX = 3'd0,
        FLAG_UF = 3'd1,
        FLAG_OF = 3'd2,
        FLAG_DZ = 3'd3,
        FLAG_NV = 3'd4
    } fflag_idx_t;

    localparam int FFLAGS_W = 5;

endpackage

// File: rtl/fpu_rm_resolve.sv
// Resolves the instruction rm field against the dynamic frm CSR and flags reserved modes.
module fpu_rm_resolve
    import fpu_ctrl_pkg::*;
(
    input  logic [2:0] i_rm,
    input  logic [2:0] i_csr_frm,
    output logic [2:0] o_rm,
    output logic       o_illegal
);

    // DYN picks up the CSR value; anything above RMM after resolution is reserved
    always_comb begin
        o_rm      = (i_rm == RM_DYN) ? i_csr_frm : i_rm;
        o_illegal = (o_rm > RM_RMM) ? 1'b1 : 1'b0;
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Issues FP instructions one at a time to the shared FPU datapath, waits for
// completion with a timeout, and keeps the sticky exception flags.
module fpu_op_sequencer
    import fpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [6:0]          req_funct7,
    input  logic [4:0]          req_rs1,
    input  logic [4:0]          req_rs2,
    input  logic [4:0]          req_rd,
    input  logic [2:0]          req_rm,
    input  logic                req_is_load,
    input  logic                req_is_store,
    input  logic [31:0]         req_load_data,
    input  logic [2:0]          csr_frm,
    input  logic                fflags_clr,
    output logic [4:0]          f_rs1,
    output logic [4:0]          f_rs2,
    output logic [4:0]          f_rd,
    output logic [2:0]          frm_in,
    output logic [7:0]          f_funct_7,
    output logic                f_LW,
    output logic                f_SW,
    output logic [31:0]         dload_ext,
    input  logic [31:0]         FPU_all_out,
    input  logic [FFLAGS_W-1:0] f_flags,
    input  logic                f_ready,
    output logic                resp_valid,
    output logic [31:0]         resp_data,
    output logic                resp_illegal,
    output logic                resp_timeout,
    output logic [FFLAGS_W-1:0] fflags,
    output logic                busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_load;
    logic                r_is_store;
    logic [FFLAGS_W-1:0] r_fflags;
    logic [2:0]          w_res_rm;
    logic                w_illegal;
    logic                w_accept;
    logic                w_capture;
    logic                w_timeout;

    fpu_rm_resolve u_rm_resolve (
        .i_rm      (req_rm),
        .i_csr_frm (csr_frm),
        .o_rm      (w_res_rm),
        .o_illegal (w_illegal)
    );

    assign w_accept  = (r_state == IDLE) && req_valid;
    assign w_capture = (r_state == WAIT) && f_ready;
    assign w_timeout = (r_state == WAIT) && !f_ready && (r_cnt == CNT_LAST);
    assign fflags    = r_fflags;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next_state = w_illegal ? RESP : ISSUE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE: begin
                if (r_is_load || r_is_store) begin
                    w_next_state = RESP;
                end else begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (f_ready || w_timeout) begin
                    w_next_state = RESP;
                end else begin
                    w_next_state = WAIT;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Latch the instruction class at accept; a load wins if both bits are set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
        end else if (w_accept) begin
            r_is_load  <= req_is_load;
            r_is_store <= req_is_store & ~req_is_load;
        end else begin
            r_is_load  <= r_is_load;
            r_is_store <= r_is_store;
        end
    end

    // Wait counter: cleared in ISSUE, counts WAIT cycles without f_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= '0;
        end else if ((r_state == WAIT) && !f_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Sticky flags: a capture merges on top of a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fflags <= '0;
        end else if (w_capture) begin
            r_fflags <= (fflags_clr ? {FFLAGS_W{1'b0}} : r_fflags) | f_flags;
        end else if (fflags_clr) begin
            r_fflags <= '0;
        end else begin
            r_fflags <= r_fflags;
        end
    end

    // FPU register/rounding selects: loaded at accept, held through ISSUE/WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            f_rs1     <= 5'd0;
            f_rs2     <= 5'd0;
            f_rd      <= 5'd0;
            frm_in    <= 3'd0;
            f_funct_7 <= 8'd0;
        end else if (w_accept && (w_next_state == ISSUE)) begin
            f_rs1     <= req_rs1;
            f_rs2     <= req_rs2;
            f_rd      <= req_rd;
            frm_in    <= w_res_rm;
            f_funct_7 <= {1'b0, req_funct7};
        end else if ((w_next_state == ISSUE) || (w_next_state == WAIT)) begin
            f_rs1     <= f_rs1;
            f_rs2     <= f_rs2;
            f_rd      <= f_rd;
            frm_in    <= frm_in;
            f_funct_7 <= f_funct_7;
        end else begin
            f_rs1     <= 5'd0;
            f_rs2     <= 5'd0;
            f_rd      <= 5'd0;
            frm_in    <= 3'd0;
            f_funct_7 <= 8'd0;
        end
    end

    // Load/store strobes and load data, asserted only for the ISSUE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            f_LW      <= 1'b0;
            f_SW      <= 1'b0;
            dload_ext <= 32'd0;
        end else begin
            f_LW      <= w_accept && (w_next_state == ISSUE) && req_is_load;
            f_SW      <= w_accept && (w_next_state == ISSUE) && req_is_store && !req_is_load;
            dload_ext <= (w_accept && (w_next_state == ISSUE) && req_is_load) ? req_load_data : 32'd0;
        end
    end

    // Handshake, status and one-cycle response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            resp_valid   <= 1'b0;
            resp_data    <= 32'd0;
            resp_illegal <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            req_ready    <= (w_next_state == IDLE);
            busy         <= (w_next_state != IDLE);
            resp_valid   <= (w_next_state == RESP);
            resp_data    <= ((r_state == ISSUE) && r_is_store) ? FPU_all_out : 32'd0;
            resp_illegal <= w_accept && w_illegal;
            resp_timeout <= w_timeout;
        end
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer: directed scenarios plus random
// operations checked against a behavioural latency/flag model.
module tb_fpu_op_sequencer;

    localparam int T      = 8;
    localparam int BUDGET = T + 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rs1, req_rs2, req_rd;
    logic [2:0]  req_rm;
    logic        req_is_load, req_is_store;
    logic [31:0] req_load_data;
    logic [2:0]  csr_frm;
    logic        fflags_clr;
    logic [4:0]  f_rs1, f_rs2, f_rd;
    logic [2:0]  frm_in;
    logic [7:0]  f_funct_7;
    logic        f_LW, f_SW;
    logic [31:0] dload_ext, FPU_all_out;
    logic [4:0]  f_flags;
    logic        f_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_illegal, resp_timeout;
    logic [4:0]  fflags;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [4:0]  m_flags  = 5'd0;

    typedef struct {
        int          lat;
        int          resp_cnt;
        int          lw_cnt;
        int          sw_cnt;
        logic [31:0] rdata;
        logic [31:0] dload;
        logic        ill;
        logic        tmo;
        logic [2:0]  frm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [7:0]  f7;
        logic        sel_stable;
        logic        sel_in_resp;
        logic [4:0]  flags_resp;
        logic        rr_start;
        logic        rr_after;
    } obs_t;

    fpu_op_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct7(req_funct7), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .req_rm(req_rm), .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_load_data(req_load_data), .csr_frm(csr_frm), .fflags_clr(fflags_clr),
        .f_rs1(f_rs1), .f_rs2(f_rs2), .f_rd(f_rd), .frm_in(frm_in), .f_funct_7(f_funct_7),
        .f_LW(f_LW), .f_SW(f_SW), .dload_ext(dload_ext), .FPU_all_out(FPU_all_out),
        .f_flags(f_flags), .f_ready(f_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_illegal(resp_illegal),
        .resp_timeout(resp_timeout), .fflags(fflags), .busy(busy)
    );

    always #5 clk = ~clk;

    // Drive one request from IDLE and record what the DUT does, cycle by cycle.
    // f_ready rises in WAIT cycle k_low+1 (n == 2+k_low); noise f_ready in the ISSUE cycle.
    task automatic run_op(input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [2:0] rm, input logic ld, input logic st,
                          input logic [31:0] ldata, input logic [2:0] csr, input int k_low,
                          input logic [4:0] fl, input logic [31:0] sval, input logic clr_at_ready,
                          output obs_t o);
        o = '{default: 0};
        o.lat = -1;
        o.sel_stable = 1'b1;
        o.rr_start = req_ready;
        req_valid = 1'b1; req_funct7 = f7; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
        req_rm = rm; req_is_load = ld; req_is_store = st; req_load_data = ldata;
        csr_frm = csr; FPU_all_out = sval; f_ready = 1'b0; f_flags = 5'd0; fflags_clr = 1'b0;
        for (int n = 1; n <= BUDGET; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                o.frm = frm_in; o.rs1 = f_rs1; o.rs2 = f_rs2; o.rd = f_rd; o.f7 = f_funct_7;
                req_valid = 1'b0; req_funct7 = 7'($urandom); req_rs1 = 5'($urandom);
                req_rs2 = 5'($urandom); req_rd = 5'($urandom); req_rm = 3'($urandom);
                req_is_load = 1'($urandom); req_is_store = 1'($urandom);
                req_load_data = $urandom; csr_frm = 3'($urandom);
            end else if (o.lat < 0 && !resp_valid &&
                         ({f_rs1, f_rs2, f_rd, frm_in, f_funct_7} !== {o.rs1, o.rs2, o.rd, o.frm, o.f7})) begin
                o.sel_stable = 1'b0;
            end
            if (f_LW) begin o.lw_cnt++; o.dload = dload_ext; end
            if (f_SW) o.sw_cnt++;
            if (resp_valid) begin
                o.resp_cnt++;
                if (o.lat < 0) begin
                    o.lat = n; o.rdata = resp_data; o.ill = resp_illegal; o.tmo = resp_timeout;
                    o.flags_resp = fflags;
                end
                if ({f_rs1, f_rs2, f_rd, frm_in, f_funct_7, f_LW, f_SW, dload_ext} != '0)
                    o.sel_in_resp = 1'b1;
            end
            if (o.lat >= 0 && n == o.lat + 1) begin
                o.rr_after = req_ready;
                break;
            end
            f_ready    = (n == 2 + k_low) || (n == 1 && ($urandom_range(0, 1) == 1));
            f_flags    = (n == 2 + k_low) ? fl : 5'($urandom);
            fflags_clr = clr_at_ready && (n == 2 + k_low);
        end
        f_ready = 1'b0; fflags_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; fflags_clr = 1'b0; f_ready = 1'b0; f_flags = 5'd0;
        req_funct7 = 7'd0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_rd = 5'd0; req_rm = 3'd0;
        req_is_load = 1'b0; req_is_store = 1'b0; req_load_data = 32'd0; csr_frm = 3'd0;
        FPU_all_out = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        n_checks++; if (fflags !== 5'd0) begin n_fail++; $display("FAIL reset_fflags got %b want 00000", fflags); end
        n_checks++;
        if ({f_LW, f_SW, frm_in, f_rs1, dload_ext, resp_data} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got nonzero f_*/resp_* want 0");
        end
        rst = 1'b0;
        @(posedge clk); #1;
        m_flags = 5'd0;
    endtask

    task automatic test_fadd();
        obs_t o;
        run_op(7'h00, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 1'b0, 32'd0, 3'b011, 4, 5'b00001, 32'd0, 1'b0, o);
        m_flags |= 5'b00001;
        n_checks++; if (o.lat !== 7) begin n_fail++; $display("FAIL fadd_latency got %0d want 7", o.lat); end
        n_checks++; if (o.flags_resp !== 5'b00001) begin n_fail++; $display("FAIL fadd_fflags got %b want 00001", o.flags_resp); end
        n_checks++; if (o.frm !== 3'b000 || !o.sel_stable) begin n_fail++; $display("FAIL fadd_frm got %b stable=%b want 000 stable=1", o.frm, o.sel_stable); end
        n_checks++; if ({o.rs1, o.rs2, o.rd} !== {5'd1, 5'd2, 5'd3}) begin n_fail++; $display("FAIL fadd_regs got %h want 0443", {o.rs1, o.rs2, o.rd}); end
    endtask

    task automatic test_dyn_rm();
        obs_t o;
        run_op(7'h08, 5'd4, 5'd5, 5'd6, 3'b111, 1'b0, 1'b0, 32'd0, 3'b010, 0, 5'b00000, 32'd0, 1'b0, o);
        n_checks++; if (o.frm !== 3'b010) begin n_fail++; $display("FAIL dyn_frm got %b want 010", o.frm); end
        n_checks++; if (o.lat !== 3) begin n_fail++; $display("FAIL dyn_latency got %0d want 3", o.lat); end
        run_op(7'h08, 5'd4, 5'd5, 5'd6, 3'b111, 1'b0, 1'b0, 32'd0, 3'b101, 0, 5'b11111, 32'd0, 1'b0, o);
        n_checks++; if (o.ill !== 1'b1) begin n_fail++; $display("FAIL dyn_illegal got %b want 1", o.ill); end
        n_checks++; if (o.lw_cnt + o.sw_cnt != 0 || o.frm !== 3'd0) begin n_fail++; $display("FAIL dyn_no_strobe got lw=%0d sw=%0d frm=%b want 0", o.lw_cnt, o.sw_cnt, o.frm); end
        n_checks++; if (o.flags_resp !== m_flags) begin n_fail++; $display("FAIL dyn_flags got %b want %b", o.flags_resp, m_flags); end
        n_checks++; if (o.lat < 1 || o.lat > 2) begin n_fail++; $display("FAIL dyn_illegal_latency got %0d want 1..2", o.lat); end
    endtask

    task automatic test_load_store();
        obs_t o;
        run_op(7'h00, 5'd0, 5'd0, 5'd7, 3'b000, 1'b1, 1'b0, 32'h3F800000, 3'b000, 0, 5'd0, 32'd0, 1'b0, o);
        n_checks++; if (o.lw_cnt != 1) begin n_fail++; $display("FAIL flw_strobe got %0d want 1", o.lw_cnt); end
        n_checks++; if (o.dload !== 32'h3F800000) begin n_fail++; $display("FAIL flw_data got %h want 3f800000", o.dload); end
        n_checks++; if (o.lat !== 2) begin n_fail++; $display("FAIL flw_latency got %0d want 2", o.lat); end
        run_op(7'h00, 5'd0, 5'd9, 5'd0, 3'b000, 1'b0, 1'b1, 32'd0, 3'b000, 0, 5'd0, 32'h40490FDB, 1'b0, o);
        n_checks++; if (o.rdata !== 32'h40490FDB) begin n_fail++; $display("FAIL fsw_data got %h want 40490fdb", o.rdata); end
        n_checks++; if (o.lat !== 2) begin n_fail++; $display("FAIL fsw_latency got %0d want 2", o.lat); end
        n_checks++; if (o.sw_cnt != 1 || o.lw_cnt != 0) begin n_fail++; $display("FAIL fsw_strobe got sw=%0d lw=%0d want 1/0", o.sw_cnt, o.lw_cnt); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_op(7'h04, 5'd1, 5'd1, 5'd1, 3'b001, 1'b0, 1'b0, 32'd0, 3'b000, 100, 5'b11111, 32'd0, 1'b0, o);
        n_checks++; if (o.tmo !== 1'b1) begin n_fail++; $display("FAIL timeout_flag got %b want 1", o.tmo); end
        n_checks++; if (o.lat !== T + 2) begin n_fail++; $display("FAIL timeout_latency got %0d want %0d", o.lat, T + 2); end
        n_checks++; if (o.flags_resp !== m_flags) begin n_fail++; $display("FAIL timeout_flags got %b want %b", o.flags_resp, m_flags); end
        n_checks++; if (o.rr_after !== 1'b1) begin n_fail++; $display("FAIL timeout_ready_after got %b want 1", o.rr_after); end
        run_op(7'h00, 5'd0, 5'd0, 5'd2, 3'b000, 1'b1, 1'b0, 32'h12345678, 3'b000, 0, 5'd0, 32'd0, 1'b0, o);
        n_checks++; if (o.lat !== 2 || o.tmo !== 1'b0) begin n_fail++; $display("FAIL timeout_next_op got lat=%0d tmo=%b want 2/0", o.lat, o.tmo); end
    endtask

    task automatic test_clr_capture();
        obs_t o;
        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        m_flags = 5'd0;
        n_checks++; if (fflags !== 5'd0) begin n_fail++; $display("FAIL clr_idle got %b want 00000", fflags); end
        run_op(7'h0C, 5'd3, 5'd4, 5'd5, 3'b000, 1'b0, 1'b0, 32'd0, 3'b000, 1, 5'b10000, 32'd0, 1'b0, o);
        n_checks++; if (o.flags_resp !== 5'b10000) begin n_fail++; $display("FAIL clr_setup got %b want 10000", o.flags_resp); end
        run_op(7'h0C, 5'd3, 5'd4, 5'd5, 3'b000, 1'b0, 1'b0, 32'd0, 3'b000, 2, 5'b00100, 32'd0, 1'b1, o);
        m_flags = 5'b00100;
        n_checks++; if (o.flags_resp !== 5'b00100) begin n_fail++; $display("FAIL clr_and_capture got %b want 00100", o.flags_resp); end
    endtask

    task automatic test_random_back_to_back();
        obs_t o;
        logic [6:0] f7; logic [4:0] rs1, rs2, rd, fl; logic [2:0] rm, csr, res;
        logic ld, st, clr, ill; logic [31:0] ldata, sval;
        int kind, k, exp_lat;
        for (int i = 0; i < 40; i++) begin
            f7 = 7'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
            rm = 3'($urandom_range(0, 7)); csr = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 3); ld = (kind == 0); st = (kind == 1);
            ldata = $urandom; sval = $urandom; fl = 5'($urandom);
            k = $urandom_range(0, T + 2); clr = ($urandom_range(0, 4) == 0) && !ld && !st;
            res = (rm == 3'b111) ? csr : rm;
            ill = (res >= 3'd5);
            if (ill) clr = 1'b0;
            run_op(f7, rs1, rs2, rd, rm, ld, st, ldata, csr, k, fl, sval, clr, o);
            exp_lat = ill ? 1 : (ld || st) ? 2 : (k < T) ? 3 + k : 2 + T;
            if (!ill && !ld && !st && k < T) m_flags = (clr ? 5'd0 : m_flags) | fl;
            n_checks++;
            if (ill ? (o.lat < 1 || o.lat > 2) : (o.lat != exp_lat)) begin
                n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, o.lat, exp_lat);
            end
            n_checks++;
            if (o.resp_cnt != 1 || o.ill !== ill || o.tmo !== (!ill && !ld && !st && k >= T)) begin
                n_fail++; $display("FAIL rnd%0d_resp got cnt=%0d ill=%b tmo=%b want 1/%b/%b", i, o.resp_cnt, o.ill, o.tmo, ill, !ill && !ld && !st && k >= T);
            end
            n_checks++;
            if (o.rdata !== ((!ill && st) ? sval : 32'd0)) begin
                n_fail++; $display("FAIL rnd%0d_resp_data got %h want %h", i, o.rdata, (!ill && st) ? sval : 32'd0);
            end
            n_checks++;
            if (o.lw_cnt != ((!ill && ld) ? 1 : 0) || o.sw_cnt != ((!ill && st) ? 1 : 0) ||
                (!ill && ld && o.dload !== ldata)) begin
                n_fail++; $display("FAIL rnd%0d_strobes got lw=%0d sw=%0d dload=%h want %0d/%0d/%h", i, o.lw_cnt, o.sw_cnt, o.dload, !ill && ld, !ill && st, ldata);
            end
            n_checks++;
            if (!ill && ({o.frm, o.rs1, o.rs2, o.rd, o.f7} !== {res, rs1, rs2, rd, 1'b0, f7} || !o.sel_stable)) begin
                n_fail++; $display("FAIL rnd%0d_selects got %h stable=%b want %h", i, {o.frm, o.rs1, o.rs2, o.rd, o.f7}, o.sel_stable, {res, rs1, rs2, rd, 1'b0, f7});
            end
            n_checks++;
            if (o.flags_resp !== m_flags) begin
                n_fail++; $display("FAIL rnd%0d_fflags got %b want %b", i, o.flags_resp, m_flags);
            end
            n_checks++;
            if (o.rr_start !== 1'b1 || o.rr_after !== 1'b1 || o.sel_in_resp) begin
                n_fail++; $display("FAIL rnd%0d_handshake got start=%b after=%b resp_sel=%b want 1/1/0", i, o.rr_start, o.rr_after, o.sel_in_resp);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int stray;
        req_valid = 1'b1; req_rm = 3'b000; req_is_load = 1'b0; req_is_store = 1'b0;
        f_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midwait_busy got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_flags = 5'd0;
        n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midwait_idle got ready=%b busy=%b want 1/0", req_ready, busy); end
        n_checks++; if (fflags !== 5'd0) begin n_fail++; $display("FAIL midwait_fflags got %b want 00000", fflags); end
        n_checks++; if ({f_rs1, frm_in, f_funct_7} !== '0) begin n_fail++; $display("FAIL midwait_selects got nonzero want 0"); end
        stray = resp_valid ? 1 : 0;
        for (int n = 0; n < T + 4; n++) begin
            f_ready = (n == 1); f_flags = 5'b11111;
            @(posedge clk); #1;
            if (resp_valid) stray++;
        end
        f_ready = 1'b0;
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL midwait_no_resp got %0d pulses want 0", stray); end
        n_checks++; if (fflags !== 5'd0) begin n_fail++; $display("FAIL midwait_ready_ignored got %b want 00000", fflags); end
    endtask

    initial begin
        test_reset();
        test_fadd();
        test_dyn_rm();
        test_load_store();
        test_timeout();
        test_clr_capture();
        test_random_back_to_back();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want end of test");
        $fatal(1);
    end

endmodule
